// File: rtl/uart_bus_responder.sv
// Memory-mapped UART on the CPU data bus: TXD / RXD / CON word registers, 8N1 framing.
// Define UART_TX_FIFO_EN to put a 4-entry FIFO in front of the transmitter.
module uart_bus_responder #(
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int          DIV      = CLK_FREQ / BAUD;
    localparam int          CW       = $clog2(DIV);
    localparam logic [31:0] RXD_ADDR = BASE_ADDR + 32'd4;
    localparam logic [31:0] CON_ADDR = BASE_ADDR + 32'd8;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic hit_txd, hit_rxd, hit_con, txd_wr, rxd_rd, con_wr;
    assign hit_txd = (addr[31:2] == BASE_ADDR[31:2]);
    assign hit_rxd = (addr[31:2] == RXD_ADDR[31:2]);
    assign hit_con = (addr[31:2] == CON_ADDR[31:2]);
    assign txd_wr  = wr & hit_txd;
    assign rxd_rd  = rd & hit_rxd;
    assign con_wr  = wr & hit_con;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    // ---------------- transmitter ----------------
    state_e          tx_state_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_sh_q;
    logic            tx_q, tx_idle, tx_last, tx_start, tx_full, tx_busy;
    logic [7:0]      tx_byte;

    assign tx_idle = (tx_state_q == S_IDLE);
    assign tx_last = (tx_cnt_q == CW'(DIV - 1));
    assign uart_tx = tx_q;

`ifdef UART_TX_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [2:0] wp_q, wp_d, rp_q, rp_d;
    logic       f_empty, push, pop;

    assign f_empty = (wp_q == rp_q);
    assign tx_full = (wp_q[1:0] == rp_q[1:0]) && (wp_q[2] != rp_q[2]);
    assign pop     = tx_idle & ~f_empty;
    // a pop on the same edge frees the slot the push lands in
    assign push    = txd_wr & (~tx_full | pop);
    assign tx_start = pop;
    assign tx_byte  = fifo_q[rp_q[1:0]];
    assign tx_busy  = ~tx_idle | ~f_empty;

    always_comb begin
        wp_d = wp_q + {2'b0, push};
        rp_d = rp_q + {2'b0, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q <= '0;
            rp_q <= '0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
            if (push) fifo_q[wp_q[1:0]] <= wdata[7:0];
        end
    end
`else
    assign tx_full  = 1'b0;
    assign tx_start = txd_wr & tx_idle;
    assign tx_byte  = wdata[7:0];
    assign tx_busy  = ~tx_idle;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                S_IDLE: if (tx_start) begin
                    tx_state_q <= S_START;
                    tx_sh_q    <= tx_byte;
                    tx_cnt_q   <= '0;
                    tx_q       <= 1'b0;
                end
                S_START: if (tx_last) begin
                    tx_state_q <= S_DATA;
                    tx_cnt_q   <= '0;
                    tx_bit_q   <= '0;
                    tx_q       <= tx_sh_q[0];
                end else tx_cnt_q <= tx_cnt_q + 1'b1;
                S_DATA: if (tx_last) begin
                    tx_cnt_q <= '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_q <= S_STOP;
                        tx_q       <= 1'b1;
                    end else begin
                        tx_bit_q <= tx_bit_q + 1'b1;
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_q     <= tx_sh_q[1];
                    end
                end else tx_cnt_q <= tx_cnt_q + 1'b1;
                S_STOP: if (tx_last) tx_state_q <= S_IDLE;
                        else tx_cnt_q <= tx_cnt_q + 1'b1;
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    state_e        rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;
    logic          rx_s1_q, rx_s2_q, rx_s3_q, rx_last, rx_half, rx_ok, rx_bad;

    assign rx_last = (rx_cnt_q == CW'(DIV - 1));
    assign rx_half = (rx_cnt_q == CW'(DIV / 2 - 1));
    assign rx_ok   = (rx_state_q == S_STOP) & rx_last & rx_s2_q;
    assign rx_bad  = (rx_state_q == S_STOP) & rx_last & ~rx_s2_q;

    // start is a falling edge, so a held-low line after a bad stop bit does not retrigger
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            {rx_s1_q, rx_s2_q, rx_s3_q} <= {uart_rx, rx_s1_q, rx_s2_q};
            case (rx_state_q)
                S_IDLE: if (rx_s3_q && !rx_s2_q) begin
                    rx_state_q <= S_START;
                    rx_cnt_q   <= '0;
                end
                S_START: if (rx_half) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
                end else rx_cnt_q <= rx_cnt_q + 1'b1;
                S_DATA: if (rx_last) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
                    else rx_bit_q <= rx_bit_q + 1'b1;
                end else rx_cnt_q <= rx_cnt_q + 1'b1;
                S_STOP: if (rx_last) rx_state_q <= S_IDLE;
                        else rx_cnt_q <= rx_cnt_q + 1'b1;
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- status / data registers ----------------
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d, overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d, rx_irq_en_q, rx_irq_en_d;

    always_comb begin
        rx_data_d   = rx_ok ? rx_sh_q : rx_data_q;
        rx_valid_d  = rx_ok | (rx_valid_q & ~rxd_rd);
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        rx_irq_en_d = rx_irq_en_q;
        if (con_wr) begin
            rx_irq_en_d = wdata[4];
            if (wdata[3]) overrun_d   = 1'b0;
            if (wdata[2]) frame_err_d = 1'b0;
        end
        // a byte landing on the edge that reads RXD replaces a consumed byte, not an unread one
        if (rx_ok && rx_valid_q && !rxd_rd) overrun_d = 1'b1;
        if (rx_bad) frame_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_irq_en_q <= 1'b0;
        end else begin
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rx_irq_en_q <= rx_irq_en_d;
        end
    end

    assign irq = rx_valid_q & rx_irq_en_q;

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (hit_rxd)      rdata = {24'b0, rx_data_q};
            else if (hit_con) rdata = {26'b0, tx_full, rx_irq_en_q, overrun_q,
                                       frame_err_q, rx_valid_q, tx_busy};
        end
    end
endmodule
